rv_lsu: RTL and testbench

- Parametrised load/store unit between the RV core datapath and a variable-latency data memory.
- Replaces the single-cycle, always-ready data-memory connection with a req/gnt/rvalid handshake.
- Generates byte enables, aligns store data, and sign/zero-extends load data for XLEN = 32 or 64.
- Stalls the core until each access completes; reports misaligned, illegal-size and timeout errors.

---
 rtl/rv_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_rv_lsu.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit between the core datapath and a variable-latency
// data memory using a req/gnt/rvalid handshake. It builds byte enables,
// lane-aligns store data, extends load data, and stalls the core until the
// access finishes. Misaligned, illegal-size and timed-out accesses complete
// with an error code.
module rv_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              in_Clk,
  input  logic              Rst,
  input  logic              in_req,
  input  logic              in_we,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wr_data,
  output logic              out_stall,
  output logic              out_done,
  output logic [XLEN-1:0]   out_rd_data,
  output logic [1:0]        out_err,
  output logic              out_mem_req,
  output logic              out_mem_we,
  output logic [XLEN-1:0]   out_mem_addr,
  output logic [XLEN/8-1:0] out_mem_be,
  output logic [XLEN-1:0]   out_mem_wdata,
  input  logic              in_mem_gnt,
  input  logic              in_mem_rvalid,
  input  logic [XLEN-1:0]   in_mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic            r_done;
  logic [1:0]      r_err;
  logic [XLEN-1:0] r_rd_data;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [NB-1:0]   r_mem_be;
  logic [XLEN-1:0] r_mem_wdata;
  logic [OB-1:0]   r_offset;
  logic [2:0]      r_funct3;
  logic [CW-1:0]   r_cnt;

  logic [OB-1:0]   w_offset;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_bad;
  logic [NB-1:0]   w_mask;
  logic            w_ack;
  logic            w_timeout;
  logic [XLEN-1:0] w_shift;
  logic            w_sign;
  logic            w_fill;
  int              w_nbits;
  logic [XLEN-1:0] w_load;

  assign out_stall     = in_req & ~r_done;
  assign out_done      = r_done;
  assign out_err       = r_err;
  assign out_rd_data   = r_rd_data;
  assign out_mem_req   = r_mem_req;
  assign out_mem_we    = r_mem_we;
  assign out_mem_addr  = r_mem_addr;
  assign out_mem_be    = r_mem_be;
  assign out_mem_wdata = r_mem_wdata;

  // Decode the incoming request: legality, alignment and the unshifted lane mask.
  always_comb begin
    w_offset  = in_addr[OB-1:0];
    w_illegal = (in_funct3 == 3'b111) || (in_we && in_funct3[2]) ||
                ((XLEN == 32) && (in_funct3 == 3'b011 || in_funct3 == 3'b110));
    case (in_funct3[1:0])
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = in_addr[0];
      2'b10:   w_misaligned = |in_addr[1:0];
      default: w_misaligned = |in_addr[2:0];
    endcase
    w_bad = w_illegal | w_misaligned;
    for (int i = 0; i < NB; i++) begin
      w_mask[i] = (i < (1 << in_funct3[1:0]));
    end
  end

  // Shift the returned word down to lane 0, then sign- or zero-extend it.
  always_comb begin
    w_shift = in_mem_rdata >> {r_offset, 3'b000};
    w_nbits = 8 << r_funct3[1:0];
    case (r_funct3[1:0])
      2'b00:   w_sign = w_shift[7];
      2'b01:   w_sign = w_shift[15];
      2'b10:   w_sign = w_shift[31];
      default: w_sign = w_shift[XLEN-1];
    endcase
    w_fill = w_sign & ~r_funct3[2];
    for (int i = 0; i < XLEN; i++) begin
      w_load[i] = (i < w_nbits) ? w_shift[i] : w_fill;
    end
  end

  // Next-state logic: completion on the handshake, abort on the cycle budget.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    if (r_state == S_REQ) begin
      w_ack = in_mem_gnt & in_mem_rvalid;
    end else if (r_state == S_WAIT) begin
      w_ack = in_mem_rvalid;
    end
    if ((r_state == S_REQ || r_state == S_WAIT) && r_cnt == CNT_LAST && !w_ack) begin
      w_timeout = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (in_req) begin
          w_state_next = w_bad ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack || w_timeout) begin
          w_state_next = S_DONE;
        end else if (in_mem_gnt) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_ack || w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge in_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered memory-side request, completion pulse, error code and load result.
  always_ff @(posedge in_Clk) begin
    if (Rst) begin
      r_done      <= 1'b0;
      r_err       <= 2'b00;
      r_rd_data   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_offset    <= '0;
      r_funct3    <= 3'b000;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_req) begin
            if (w_bad) begin
              r_done    <= 1'b1;
              r_err     <= w_illegal ? 2'b10 : 2'b01;
              r_rd_data <= '0;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= in_we;
              r_mem_addr  <= {in_addr[XLEN-1:OB], {OB{1'b0}}};
              r_mem_be    <= w_mask << w_offset;
              r_mem_wdata <= in_wr_data << {w_offset, 3'b000};
              r_offset    <= w_offset;
              r_funct3    <= in_funct3;
              r_cnt       <= '0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_ack) begin
            r_done    <= 1'b1;
            r_err     <= 2'b00;
            r_rd_data <= r_mem_we ? '0 : w_load;
            r_mem_req <= 1'b0;
          end else if (w_timeout) begin
            r_done    <= 1'b1;
            r_err     <= 2'b11;
            r_rd_data <= '0;
            r_mem_req <= 1'b0;
          end else if (in_mem_gnt) begin
            r_mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed bench for rv_lsu. A 64-bit instance is checked every
// cycle against a transaction-level model of lanes, extension, error codes
// and latency; a 32-bit instance covers the XLEN-dependent size rules.
module tb_rv_lsu;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst;

  // 64-bit instance
  logic        req, we;
  logic [2:0]  f3;
  logic [63:0] addr, wdata;
  logic        stall, done, mreq, mwe;
  logic [63:0] rd, maddr, mwd;
  logic [1:0]  err;
  logic [7:0]  mbe;
  logic        gnt, mem_rv, mem_stray, rvalid;
  logic [63:0] k_rdata;

  // 32-bit instance
  logic        d_req, d_we;
  logic [2:0]  d_f3;
  logic [31:0] d_addr, d_wdata;
  logic        d_stall, d_done, d_mreq, d_mwe;
  logic [31:0] d_rd, d_maddr, d_mwd;
  logic [1:0]  d_err;
  logic [3:0]  d_mbe;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // model / bookkeeping
  bit          started = 0;
  bit          m_active = 0;
  logic        m_we;
  logic [2:0]  m_f3;
  logic [63:0] m_addr, m_wr, m_rdata;
  logic [1:0]  m_exp_err;
  int          n_done = 0;
  int          n_req_cyc = 0;
  logic [63:0] last_rd, last_addr, last_wd;
  logic [1:0]  last_err;
  logic [7:0]  last_be;
  logic        last_we;

  // memory responder knobs
  int          k_gnt_d = 0, k_rv_d = 0;
  bit          k_rv_never = 0;
  bit          mem_reset_req = 0;

  assign rvalid   = mem_rv | mem_stray;
  assign d_gnt    = d_mreq;
  assign d_rvalid = d_mreq;

  rv_lsu #(.XLEN(64), .TIMEOUT(TB_TIMEOUT)) u_dut (
    .in_Clk(clk), .Rst(rst), .in_req(req), .in_we(we), .in_funct3(f3),
    .in_addr(addr), .in_wr_data(wdata), .out_stall(stall), .out_done(done),
    .out_rd_data(rd), .out_err(err), .out_mem_req(mreq), .out_mem_we(mwe),
    .out_mem_addr(maddr), .out_mem_be(mbe), .out_mem_wdata(mwd),
    .in_mem_gnt(gnt), .in_mem_rvalid(rvalid), .in_mem_rdata(k_rdata)
  );

  rv_lsu #(.XLEN(32), .TIMEOUT(TB_TIMEOUT)) u_dut32 (
    .in_Clk(clk), .Rst(rst), .in_req(d_req), .in_we(d_we), .in_funct3(d_f3),
    .in_addr(d_addr), .in_wr_data(d_wdata), .out_stall(d_stall), .out_done(d_done),
    .out_rd_data(d_rd), .out_err(d_err), .out_mem_req(d_mreq), .out_mem_we(d_mwe),
    .out_mem_addr(d_maddr), .out_mem_be(d_mbe), .out_mem_wdata(d_mwd),
    .in_mem_gnt(d_gnt), .in_mem_rvalid(d_rvalid), .in_mem_rdata(d_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int f_size(input logic [2:0] fc);
    return 1 << fc[1:0];
  endfunction

  function automatic logic [1:0] f_err(input logic [63:0] a, input logic [2:0] fc,
                                       input logic w, input int xlen);
    if (fc == 3'b111 || (xlen == 32 && (fc == 3'b011 || fc == 3'b110)) || (w && fc[2]))
      return 2'b10;
    if ((a % f_size(fc)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] f_be(input logic [63:0] a, input logic [2:0] fc);
    int off = int'(a % 8);
    return 8'(((1 << f_size(fc)) - 1) << off);
  endfunction

  function automatic logic [63:0] f_wdata(input logic [63:0] a, input logic [63:0] w);
    int off = int'(a % 8);
    return w << (8 * off);
  endfunction

  function automatic logic [63:0] f_load(input logic [63:0] r, input logic [63:0] a,
                                         input logic [2:0] fc);
    int off = int'(a % 8);
    int nb = 8 * f_size(fc);
    logic [63:0] v = r >> (8 * off);
    logic [63:0] mask = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    v = v & mask;
    if (!fc[2] && nb < 64 && v[nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- memory responder ----------------
  initial begin : mem_proc
    int ph, w, rc;
    gnt = 0; mem_rv = 0; ph = 0; w = 0; rc = 0;
    forever begin
      @(posedge clk); #2;
      gnt = 0; mem_rv = 0;
      if (mem_reset_req) begin
        ph = 0; w = 0; rc = 0;
      end else if (ph == 0) begin
        if (mreq) begin
          if (w == k_gnt_d) begin
            gnt = 1; w = 0;
            if (k_rv_d == 0 && !k_rv_never) mem_rv = 1;
            else begin ph = 1; rc = 0; end
          end else w++;
        end
      end else begin
        rc++;
        if (!k_rv_never && rc == k_rv_d) begin mem_rv = 1; ph = 0; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started && !rst) begin
      check("stall", stall, req & ~done);
      if (!m_active) begin
        check("idle_done", done, 0);
        check("idle_mem_req", mreq, 0);
      end else begin
        if (m_exp_err == 2'b01 || m_exp_err == 2'b10) check("err_no_mem_req", mreq, 0);
        if (mreq) begin
          n_req_cyc++;
          last_addr = maddr; last_be = mbe; last_wd = mwd; last_we = mwe;
          check("mem_addr", maddr, {m_addr[63:3], 3'b000});
          check("mem_be", mbe, f_be(m_addr, m_f3));
          check("mem_wdata", mwd, f_wdata(m_addr, m_wr));
          check("mem_we", mwe, m_we);
        end
        if (done) begin
          n_done++;
          last_err = err; last_rd = rd;
          check("done_err", err, m_exp_err);
          if (m_exp_err != 2'b11)
            check("done_rd", rd, (m_we || m_exp_err != 2'b00) ? 64'd0 : f_load(m_rdata, m_addr, m_f3));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_op(input string nm, input logic we_i, input logic [2:0] f3_i,
                       input logic [63:0] a_i, input logic [63:0] wd_i, input logic [63:0] rd_i,
                       input int gd, input int rvd, input bit never, input bit keep,
                       output int lat);
    logic [1:0] e;
    bit got;
    int exp_lat;
    e = f_err(a_i, f3_i, we_i, 64);
    if (e == 2'b00 && (never || gd + rvd >= TB_TIMEOUT)) e = 2'b11;
    m_we = we_i; m_f3 = f3_i; m_addr = a_i; m_wr = wd_i; m_rdata = rd_i;
    m_exp_err = e; m_active = 1;
    k_gnt_d = gd; k_rv_d = rvd; k_rv_never = never; k_rdata = rd_i; mem_reset_req = 1;
    req = 1; we = we_i; f3 = f3_i; addr = a_i; wdata = wd_i;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      mem_reset_req = 0;
      lat++;
      if (done) got = 1;
    end
    if (e == 2'b01 || e == 2'b10) exp_lat = 1;
    else if (e == 2'b11) exp_lat = TB_TIMEOUT + 1;
    else exp_lat = 2 + gd + rvd;
    check({nm, "_latency"}, got ? 64'(lat) : 64'd0, 64'(exp_lat));
    @(posedge clk); #1;
    check({nm, "_pulse_width"}, done, 0);
    if (!keep) begin
      req = 0; m_active = 0;
    end
  endtask

  task automatic op32(input string nm, input logic [2:0] f3_i, input logic [31:0] a_i,
                      input logic [1:0] e_exp, input logic [31:0] rd_exp,
                      input logic [3:0] be_exp, input int lat_exp);
    int lat;
    bit got;
    logic [3:0] be_seen;
    logic [1:0] err_seen;
    logic [31:0] rd_seen;
    d_req = 1; d_f3 = f3_i; d_addr = a_i; d_we = 0;
    be_seen = 0; err_seen = 0; rd_seen = 0;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (d_mreq) be_seen = d_mbe;
      if (d_done) begin got = 1; err_seen = d_err; rd_seen = d_rd; end
    end
    check({nm, "_latency"}, got ? 64'(lat) : 64'd0, 64'(lat_exp));
    check({nm, "_err"}, err_seen, e_exp);
    check({nm, "_rd"}, rd_seen, rd_exp);
    check({nm, "_be"}, be_seen, be_exp);
    @(posedge clk); #1;
    d_req = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, base_req, base_done;
    rst = 1; mem_stray = 0; k_rdata = 0;
    req = 0; we = 0; f3 = 0; addr = 0; wdata = 0;
    d_req = 0; d_we = 0; d_f3 = 0; d_addr = 0; d_wdata = 0; d_rdata = 32'h8001_0000;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    started = 1;

    // reset state of both instances
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd", rd, 0);
    check("rst_mem_req", mreq, 0);
    check("rst_mem_be", mbe, 0);
    check("rst_mem_addr", maddr, 0);
    check("rst32_mem_req", d_mreq, 0);
    check("rst32_done", d_done, 0);

    // LB / LBU with zero-wait memory
    do_op("lb", 0, 3'b000, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 0, lat);
    check("lb_lat_lit", lat, 2);
    check("lb_rd_lit", last_rd, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_be_lit", last_be, 8'h08);
    do_op("lbu", 0, 3'b100, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 0, lat);
    check("lbu_rd_lit", last_rd, 64'h80);

    // SW with grant delayed 4 cycles
    base_req = n_req_cyc;
    do_op("sw", 1, 3'b010, 64'h2004, 64'h1234_5678, 0, 4, 1, 0, 0, lat);
    check("sw_addr_lit", last_addr, 64'h2000);
    check("sw_be_lit", last_be, 8'hF0);
    check("sw_wdata_lit", last_wd, 64'h1234_5678_0000_0000);
    check("sw_we_lit", last_we, 1);
    check("sw_req_cycles", n_req_cyc - base_req, 5);
    check("sw_rd_lit", last_rd, 0);

    // error paths
    do_op("lh_mis", 0, 3'b001, 64'h1001, 0, 0, 0, 0, 0, 0, lat);
    check("lh_mis_lat_lit", lat, 1);
    check("lh_mis_err_lit", last_err, 2'b01);
    do_op("f3_111", 0, 3'b111, 64'h1001, 0, 0, 0, 0, 0, 0, lat);
    check("f3_111_err_lit", last_err, 2'b10);
    do_op("st_unsigned", 1, 3'b100, 64'h1000, 64'hAB, 0, 0, 0, 0, 0, lat);

    // other lanes and sizes
    do_op("lh_hi", 0, 3'b001, 64'h1006, 0, 64'h8001_0000_0000_0000, 1, 2, 0, 0, lat);
    do_op("sb", 1, 3'b000, 64'h3005, 64'hFFFF_FFFF_FFFF_FFA5, 0, 0, 2, 0, 0, lat);
    do_op("lwu", 0, 3'b110, 64'h4004, 0, 64'hF000_0001_0000_0000, 0, 0, 0, 0, lat);

    // timeout, and rvalid on the last budget cycle
    do_op("timeout", 0, 3'b010, 64'h30, 0, 0, 0, 0, 1, 0, lat);
    check("timeout_lat_lit", lat, 9);
    check("timeout_err_lit", last_err, 2'b11);
    do_op("rv_wins", 0, 3'b011, 64'h38, 0, 64'hFEDC_BA98_7654_3210, 4, 3, 0, 0, lat);
    check("rv_wins_lat_lit", lat, 9);
    check("rv_wins_err_lit", last_err, 2'b00);

    // reset while waiting for rvalid; late rvalid must be ignored
    base_done = n_done;
    m_we = 0; m_f3 = 3'b010; m_addr = 64'h40; m_wr = 0; m_rdata = 0; m_exp_err = 2'b00;
    m_active = 1;
    k_gnt_d = 0; k_rv_d = 0; k_rv_never = 1; mem_reset_req = 1;
    req = 1; we = 0; f3 = 3'b010; addr = 64'h40; wdata = 0;
    @(posedge clk); #1 mem_reset_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1; req = 0; m_active = 0;
    @(posedge clk); #1 rst = 0;
    check("mid_rst_mem_req", mreq, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_be", mbe, 0);
    check("mid_rst_addr", maddr, 0);
    check("mid_rst_wdata", mwd, 0);
    mem_stray = 1;
    @(posedge clk); #1 mem_stray = 0;
    repeat (3) @(posedge clk);
    #1 check("mid_rst_no_done", n_done - base_done, 0);

    do_op("lw_after_rst", 0, 3'b010, 64'h44, 0, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, lat);
    check("lw_after_rst_rd_lit", last_rd, 64'h1234_5678);

    // back-to-back loads with in_req held high
    base_done = n_done;
    do_op("b2b_0", 0, 3'b011, 64'h10, 0, 64'h1111_2222_3333_4444, 0, 0, 0, 1, lat);
    do_op("b2b_1", 0, 3'b011, 64'h18, 0, 64'h5555_6666_7777_8888, 0, 0, 0, 0, lat);
    check("b2b_second_lat_lit", lat, 2);
    check("b2b_done_count", n_done - base_done, 2);
    check("b2b_rd_lit", last_rd, 64'h5555_6666_7777_8888);

    // XLEN = 32 instance
    op32("x32_ld", 3'b011, 32'h1000, 2'b10, 32'h0, 4'h0, 1);
    op32("x32_ld_mis", 3'b011, 32'h1001, 2'b10, 32'h0, 4'h0, 1);
    op32("x32_lwu", 3'b110, 32'h1000, 2'b10, 32'h0, 4'h0, 1);
    op32("x32_lh", 3'b001, 32'h1002, 2'b00, 32'hFFFF_8001, 4'hC, 2);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
